// File: rtl/sobol_gen.sv
// 1-D Gray-code Sobol sequence generator with a loadable direction-number table.
// Emits u in (0,1) as an unsigned QFRAC-bit fraction over a valid/ready port.
package fpga_cfg_pkg;
    localparam int FP_WIDTH = 32;
    localparam int FP_QFRAC = 16;
endpackage

module sobol_gen #(
    parameter int  WIDTH  = fpga_cfg_pkg::FP_WIDTH,
    parameter int  QFRAC  = fpga_cfg_pkg::FP_QFRAC,
    parameter int  NBITS  = 32,
    parameter int  MAXLOG = 20,
    localparam int AW     = $clog2(MAXLOG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dir_we,
    input  logic [AW-1:0]     dir_addr,
    input  logic [NBITS-1:0]  dir_data,
    input  logic              start,
    input  logic [MAXLOG-1:0] seq_len,
    output logic              busy,
    output logic              done,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [WIDTH-1:0]  u
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [NBITS-1:0]  v_tab [MAXLOG];
    logic [NBITS-1:0]  x;
    logic [NBITS-1:0]  x_nxt;
    logic [MAXLOG-1:0] idx;
    logic [MAXLOG-1:0] remaining;
    logic [AW-1:0]     c_idx;
    logic              c_found;
    logic [QFRAC-1:0]  frac;
    logic [WIDTH-1:0]  u_nxt;
    logic              load;
    logic              xfer;
    logic              tab_wr;

    assign busy   = (state != S_IDLE);
    assign xfer   = valid_out && ready_in;
    assign tab_wr = (state == S_IDLE) && dir_we && (32'(dir_addr) < 32'(MAXLOG));

    // Gray-code step: flip the direction number at the lowest zero bit of idx.
    always_comb begin
        c_idx   = '0;
        c_found = 1'b0;
        for (int unsigned i = 0; i < MAXLOG; i++) begin
            if (!c_found && !idx[i]) begin
                c_idx   = AW'(i);
                c_found = 1'b1;
            end
        end
    end

    assign x_nxt = x ^ v_tab[c_idx];
    assign frac  = x_nxt[NBITS-1 -: QFRAC];
    // Zero never leaves the block; a truncated zero becomes one LSB.
    assign u_nxt = (frac == '0) ? WIDTH'(1) : WIDTH'(frac);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (seq_len != '0)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!valid_out || ready_in) begin
                    load = 1'b1;
                    if (remaining == MAXLOG'(1)) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < MAXLOG; k++) begin
                v_tab[k] <= NBITS'(1) << (NBITS - 1 - k);
            end
        end else if (tab_wr) begin
            v_tab[dir_addr] <= dir_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            idx       <= '0;
            remaining <= '0;
            valid_out <= 1'b0;
            u         <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (seq_len != '0) begin
                            remaining <= seq_len;
                            x         <= '0;
                            idx       <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (load) begin
                        x         <= x_nxt;
                        idx       <= idx + MAXLOG'(1);
                        remaining <= remaining - MAXLOG'(1);
                        u         <= u_nxt;
                        valid_out <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (xfer) begin
                        valid_out <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobol_gen.sv
// Self-checking bench for sobol_gen: randomized tables, lengths and ready patterns
// checked against a Gray-code formula model of the Sobol sequence.
module tb_sobol_gen;
    localparam int NBITS  = 32;
    localparam int MAXLOG = 20;
    localparam int QFRAC  = 16;
    localparam int WIDTH  = 32;
    localparam int AW     = 5;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              dir_we   = 1'b0;
    logic [AW-1:0]     dir_addr = '0;
    logic [NBITS-1:0]  dir_data = '0;
    logic              start    = 1'b0;
    logic [MAXLOG-1:0] seq_len  = '0;
    logic              ready_in = 1'b1;
    logic              busy;
    logic              done;
    logic              valid_out;
    logic [WIDTH-1:0]  u;

    int checks = 0;
    int errors = 0;

    logic [NBITS-1:0] mv [MAXLOG];
    logic [WIDTH-1:0] got [$];
    logic [WIDTH-1:0] lit8 [8];

    sobol_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dir_we    (dir_we),
        .dir_addr  (dir_addr),
        .dir_data  (dir_data),
        .start     (start),
        .seq_len   (seq_len),
        .busy      (busy),
        .done      (done),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .u         (u)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < MAXLOG; k++) mv[k] = 32'h8000_0000 >> k;
    endtask

    // Sobol point n is the XOR of direction numbers selected by the bits of gray(n).
    function automatic logic [WIDTH-1:0] ref_point(input int unsigned n);
        logic [31:0]      g;
        logic [NBITS-1:0] xv;
        logic [QFRAC-1:0] f;
        g  = n ^ (n >> 1);
        xv = '0;
        for (int j = 0; j < MAXLOG; j++) if (g[j]) xv = xv ^ mv[j];
        f = xv[NBITS-1 -: QFRAC];
        return (f == '0) ? WIDTH'(1) : WIDTH'(f);
    endfunction

    task automatic write_dir(input int unsigned wa, input logic [NBITS-1:0] wd);
        @(negedge clk);
        dir_we   = 1'b1;
        dir_addr = AW'(wa);
        dir_data = wd;
        @(negedge clk);
        dir_we = 1'b0;
        if (wa < MAXLOG) mv[wa] = wd;
    endtask

    // mode: 0 ready high, 1 toggle, 2 stall 3 cycles on first valid, 3 random
    task automatic run_seq(input int len, input int mode, input bit do_wr,
                           input int unsigned wa, input logic [NBITS-1:0] wd);
        int               cyc;
        int               budget;
        int               first_valid;
        int               stall;
        bit               seen_done;
        bit               prev_valid;
        bit               prev_ready;
        bit               prev_xfer;
        logic [WIDTH-1:0] prev_u;
        got.delete();
        @(negedge clk);
        start    = 1'b1;
        seq_len  = MAXLOG'(len);
        ready_in = 1'b1;
        if (do_wr) begin
            dir_we   = 1'b1;
            dir_addr = AW'(wa);
            dir_data = wd;
            if (wa < MAXLOG) mv[wa] = wd;
        end
        cyc = 0; budget = len * 6 + 20; first_valid = -1; stall = 0;
        seen_done = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_xfer = 1'b0; prev_u = '0;
        while (!seen_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start  = 1'b0;
            dir_we = 1'b0;
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 64'(valid_out), 64'(1));
                check("hold_u", 64'(u), 64'(prev_u));
            end
            if (valid_out && first_valid < 0) first_valid = cyc;
            if (done) begin
                seen_done = 1'b1;
                if (len != 0) check("done_after_xfer", 64'(prev_xfer), 64'(1));
                else          check("done_len0_lat", 64'(cyc), 64'(1));
                if (len != 0 && mode == 0) check("done_lat_b2b", 64'(cyc), 64'(len + 2));
                check("idle_busy", 64'(busy), 64'(0));
                check("idle_valid", 64'(valid_out), 64'(0));
            end else begin
                if (cyc == 3 && busy) begin
                    start    = 1'b1;
                    dir_we   = 1'b1;
                    dir_addr = '0;
                    dir_data = $urandom;
                end
                case (mode)
                    0: ready_in = 1'b1;
                    1: ready_in = ~ready_in;
                    2: begin
                        if (valid_out && stall < 3) begin
                            ready_in = 1'b0;
                            stall++;
                        end else begin
                            ready_in = 1'b1;
                        end
                    end
                    default: ready_in = 1'($urandom_range(0, 1));
                endcase
                if (valid_out && ready_in) got.push_back(u);
            end
            prev_valid = valid_out;
            prev_ready = ready_in;
            prev_u     = u;
            prev_xfer  = valid_out && ready_in;
        end
        if (!seen_done) check("done_timeout", 64'(0), 64'(1));
        if (len != 0) check("first_valid_lat", 64'(first_valid), 64'(2));
        else          check("no_valid_len0", 64'(first_valid), 64'(-1));
        check("count", 64'(got.size()), 64'(len));
        for (int i = 0; i < got.size() && i < len; i++)
            check($sformatf("u[%0d]", i + 1), 64'(got[i]), 64'(ref_point(i + 1)));
    endtask

    task automatic check_lit(input int n);
        for (int i = 0; i < n && i < got.size(); i++)
            check($sformatf("lit[%0d]", i), 64'(got[i]), 64'(lit8[i]));
    endtask

    initial begin
        lit8[0] = 32'h8000; lit8[1] = 32'hC000; lit8[2] = 32'h4000; lit8[3] = 32'h6000;
        lit8[4] = 32'hE000; lit8[5] = 32'hA000; lit8[6] = 32'h2000; lit8[7] = 32'h3000;
        model_reset();
        #12;
        check("rst_valid", 64'(valid_out), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_u", 64'(u), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_seq(4, 0, 1'b0, 0, '0);
        check_lit(4);
        run_seq(4, 2, 1'b0, 0, '0);
        check_lit(4);
        run_seq(8, 1, 1'b0, 0, '0);
        check_lit(8);

        write_dir(0, 32'h0000_0001);
        run_seq(1, 0, 1'b0, 0, '0);
        if (got.size() > 0) check("clamp_v0_1", 64'(got[0]), 64'(1));
        write_dir(0, 32'h0000_0000);
        run_seq(1, 0, 1'b0, 0, '0);
        if (got.size() > 0) check("clamp_v0_0", 64'(got[0]), 64'(1));

        write_dir(25, $urandom);
        run_seq(6, 3, 1'b0, 0, '0);
        run_seq(0, 0, 1'b0, 0, '0);
        run_seq(5, 0, 1'b1, 1, $urandom);

        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 1)
                write_dir($urandom_range(0, MAXLOG - 1),
                          ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom));
            run_seq($urandom_range(1, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 31), $urandom);
        end

        @(negedge clk);
        start    = 1'b1;
        seq_len  = MAXLOG'(10);
        ready_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", 64'(valid_out), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(valid_out), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_u", 64'(u), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_seq(4, 0, 1'b0, 0, '0);
        check_lit(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
